// File: rtl/gcd_core.sv
// gcd_core -- iterative greatest-common-divisor engine using repeated subtraction.
//
// A request is accepted while idle. The two operands are captured into working
// registers ca/cb. On each RUN cycle the smaller operand is subtracted from the
// larger one. When either operand reaches zero, the other one is the result.
// The result is presented on opt together with a one-cycle done pulse.
//
// Optional build macro: GCD_ITER_CNT_EN adds the iter_cnt output. It is a
// saturating count of subtraction steps for the current or most recent
// computation. Without the macro, the port and its counter are not built.

module gcd_core_chk #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    input logic             busy,
    input logic             done,
    input logic [WIDTH-1:0] opt
);

    // done is a pulse: a new computation needs at least two cycles after acceptance.
    a_done_single : assert property (@(posedge clk) disable iff (rst) done |=> !done);

    // The result is only presented once the engine has returned to idle.
    a_done_idle : assert property (@(posedge clk) disable iff (rst) done |-> !busy);

    // Reset leaves the block idle with a cleared result.
    a_reset_clears : assert property (@(posedge clk)
        rst |=> (!busy && !done && (opt == {WIDTH{1'b0}})));

    // opt only moves together with a done pulse or because of reset.
    a_opt_stable : assert property (@(posedge clk) disable iff (rst)
        (!done && !$past(rst)) |-> $stable(opt));

endmodule

module gcd_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] opt
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [WIDTH-1:0] iter_cnt
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    state_t           state_r;
    logic [WIDTH-1:0] ca_r;
    logic [WIDTH-1:0] cb_r;
    logic [WIDTH-1:0] opt_r;
    logic             busy_r;
    logic             done_r;

    logic             operand_zero_s;
    logic             ca_ge_cb_s;
    logic [WIDTH-1:0] diff_ab_s;
    logic [WIDTH-1:0] diff_ba_s;
    logic [WIDTH-1:0] result_s;

    // Datapath: zero detect, compare, and both candidate differences.
    // Only the difference with the larger operand as minuend is ever used,
    // so the unused one may wrap without effect.
    always_comb begin
        operand_zero_s = (ca_r == ZERO_W) || (cb_r == ZERO_W);
        ca_ge_cb_s     = (ca_r >= cb_r);
        diff_ab_s      = ca_r - cb_r;
        diff_ba_s      = cb_r - ca_r;
        result_s       = ca_r | cb_r;
    end

    // Control FSM: working operands and registered busy/done/opt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ca_r    <= ZERO_W;
            cb_r    <= ZERO_W;
            opt_r   <= ZERO_W;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            // done is a pulse by default; only the finishing RUN edge raises it
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // start is only looked at here, so requests while busy are dropped
                    if (start) begin
                        ca_r    <= a;
                        cb_r    <= b;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (operand_zero_s) begin
                        // With one operand at zero, the OR yields the other one (or zero)
                        opt_r   <= result_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (ca_ge_cb_s) begin
                        ca_r <= diff_ab_s;
                    end else begin
                        cb_r <= diff_ba_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign opt  = opt_r;

`ifdef GCD_ITER_CNT_EN
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] iter_cnt_r;
    logic             accept_s;
    logic             step_s;
    logic             iter_sat_s;

    // Counter events derived from the FSM: new request accepted, or one subtraction step.
    always_comb begin
        accept_s   = (state_r == IDLE) && start;
        step_s     = (state_r == RUN) && !operand_zero_s;
        iter_sat_s = &iter_cnt_r;
    end

    // Saturating step counter. It clears on acceptance and holds after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cnt_r <= ZERO_W;
        end else if (accept_s) begin
            iter_cnt_r <= ZERO_W;
        end else if (step_s && !iter_sat_s) begin
            iter_cnt_r <= iter_cnt_r + ONE_W;
        end
    end

    assign iter_cnt = iter_cnt_r;
`endif

    gcd_core_chk #(
        .WIDTH(WIDTH)
    ) u_chk (
        .clk (clk),
        .rst (rst),
        .busy(busy_r),
        .done(done_r),
        .opt (opt_r)
    );

endmodule

// File: tb/tb_gcd_core.sv
// tb_gcd_core -- scoreboard bench for gcd_core (WIDTH=32 and WIDTH=8 instances).
// The reference model uses Euclid's division algorithm.
// The subtraction-step count of the DUT equals the sum of the Euclid quotients.
// Timing: start in cycle c, done in cycle c+steps+2.

module tb_gcd_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32, start8;
    logic [31:0] a32, b32, opt32;
    logic [7:0]  a8, b8, opt8;
    logic        busy32, done32, busy8, done8;
`ifdef GCD_ITER_CNT_EN
    logic [31:0] iter32;
    logic [7:0]  iter8;
`endif

    typedef struct {
        longint unsigned opt;
        longint unsigned iter;
        int unsigned     done_cyc;
    } exp_t;

    exp_t            q32[$];
    exp_t            q8[$];
    exp_t            e32, e8;
    int unsigned     cyc = 0;
    int              checks = 0;
    int              failures = 0;
    bit              mon_en = 1'b0;
    bit              rst_pend = 1'b0;
    longint unsigned hold32 = 0;
    longint unsigned hold8 = 0;

    gcd_core #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .opt(opt32)
`ifdef GCD_ITER_CNT_EN
        , .iter_cnt(iter32)
`endif
    );

    gcd_core #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .opt(opt8)
`ifdef GCD_ITER_CNT_EN
        , .iter_cnt(iter8)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle index; a start driven while cyc==c is "cycle 0" of that request
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Euclid: gcd and the number of subtractions the subtractive algorithm needs
    function automatic void gcd_ref(input longint unsigned x, input longint unsigned y,
                                    output longint unsigned g, output longint unsigned steps);
        longint unsigned p, q, r;
        steps = 0;
        if (x == 0 || y == 0) begin
            g = x | y;
            return;
        end
        p = (x > y) ? x : y;
        q = (x > y) ? y : x;
        while (q != 0) begin
            steps += p / q;
            r = p % q;
            p = q;
            q = r;
        end
        g = p;
    endfunction

    function automatic longint unsigned sat(input longint unsigned v, input int w);
        longint unsigned m;
        m = (64'd1 << w) - 64'd1;
        return (v > m) ? m : v;
    endfunction

    task automatic expect_push(input bit is8, input longint unsigned x, input longint unsigned y,
                               input int unsigned acc, output int unsigned dc);
        longint unsigned g, steps;
        exp_t e;
        gcd_ref(x, y, g, steps);
        e.opt      = g;
        e.iter     = sat(steps, is8 ? 8 : 32);
        e.done_cyc = acc + int'(steps) + 2;
        dc         = e.done_cyc;
        if (is8) q8.push_back(e);
        else     q32.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One request on the 32-bit DUT; junk=1 throws ignored starts while busy
    task automatic run32(input logic [31:0] x, input logic [31:0] y, input bit junk, input int gap);
        int unsigned acc, dc;
        start32 = 1'b1; a32 = x; b32 = y; acc = cyc;
        expect_push(1'b0, x, y, acc, dc);
        step();
        chk("busy32_after_start", busy32, 1);
        start32 = 1'b0;
        while (cyc < dc) begin
            if (junk) begin
                start32 = 1'($urandom_range(0, 1));
                a32 = $urandom; b32 = $urandom;
            end
            step();
        end
        start32 = 1'b0;
        repeat (gap) step();
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input int gap);
        int unsigned acc, dc;
        start8 = 1'b1; a8 = x; b8 = y; acc = cyc;
        expect_push(1'b1, x, y, acc, dc);
        step();
        chk("busy8_after_start", busy8, 1);
        start8 = 1'b0;
        while (cyc < dc) step();
        repeat (gap) step();
    endtask

    // Scoreboard monitor: pops on every done, checks opt/iter/timing, and checks opt holds otherwise
    always @(negedge clk) begin
        if (rst_pend) begin
            hold32 = 0;
            hold8  = 0;
        end
        if (mon_en) begin
            if (done32) begin
                chk("done32_has_expected", (q32.size() > 0), 1);
                if (q32.size() > 0) begin
                    e32 = q32.pop_front();
                    chk("opt32", opt32, e32.opt);
                    chk("done32_cycle", cyc, e32.done_cyc);
`ifdef GCD_ITER_CNT_EN
                    chk("iter32", iter32, e32.iter);
`endif
                    hold32 = e32.opt;
                end
            end else begin
                chk("opt32_hold", opt32, hold32);
            end
            if (done8) begin
                chk("done8_has_expected", (q8.size() > 0), 1);
                if (q8.size() > 0) begin
                    e8 = q8.pop_front();
                    chk("opt8", opt8, e8.opt);
                    chk("done8_cycle", cyc, e8.done_cyc);
`ifdef GCD_ITER_CNT_EN
                    chk("iter8", iter8, e8.iter);
`endif
                    hold8 = e8.opt;
                end
            end else begin
                chk("opt8_hold", opt8, hold8);
            end
        end
        rst_pend = rst;
    end

    // Watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int unsigned acc, dc, dc2, c;
        logic [31:0] x, y;

        rst = 1'b1; start32 = 1'b0; start8 = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_busy32", busy32, 0);
        chk("rst_done32", done32, 0);
        chk("rst_opt32", opt32, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_opt8", opt8, 0);
`ifdef GCD_ITER_CNT_EN
        chk("rst_iter32", iter32, 0);
`endif
        mon_en = 1'b1;

        // Directed cases
        run32(32'd12, 32'd18, 1'b0, 1);
        run32(32'd7, 32'd0, 1'b0, 1);
        run32(32'd0, 32'd7, 1'b0, 0);
        run32(32'd0, 32'd0, 1'b0, 2);
        run32(32'd17, 32'd17, 1'b0, 0);
        run32(32'd1, 32'd100, 1'b1, 1);

        // start held high: one done, then re-accepted in the done cycle
        acc = cyc; start32 = 1'b1; a32 = 32'd12; b32 = 32'd18;
        expect_push(1'b0, 64'd12, 64'd18, acc, dc);
        do begin
            step();
            a32 = $urandom; b32 = $urandom;
        end while (cyc < dc);
        a32 = 32'd35; b32 = 32'd21;
        expect_push(1'b0, 64'd35, 64'd21, cyc, dc2);
        step();
        start32 = 1'b0; a32 = $urandom; b32 = $urandom;
        while (cyc < dc2) step();
        repeat (2) step();

        // Reset two cycles after start: abort, no done, opt cleared
        c = cyc; start32 = 1'b1; a32 = 32'd12; b32 = 32'd18;
        step();
        start32 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy32", busy32, 0);
        chk("abort_done32", done32, 0);
        chk("abort_opt32", opt32, 0);
        chk("abort_cycle", cyc, c + 3);
        repeat (10) step();

        // 8-bit instance
        run8(8'd255, 8'd1, 1);
        run8(8'd12, 8'd18, 0);
        run8(8'd0, 8'd9, 1);

        // Randomized requests with random gaps and ignored starts while busy
        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 200));
            y = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 200));
            run32(x, y, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        repeat (5) step();
        chk("q32_drained", q32.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
